// File: rtl/ah_snoop_pkg.sv
// Shared definitions for the snoop issuer: FSM state encoding and the
// default widths of the snoop data, snoop key and requester tag.
package ah_snoop_pkg;

    localparam int DATA_W_DEF = 110;
    localparam int KEY_W_DEF  = 32;
    localparam int TAG_W_DEF  = 8;

    // S_ prefix keeps S_BACKOFF distinct from the BACKOFF delay parameter.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_BACKOFF = 3'd3,
        S_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/ah_down_counter.sv
// Loadable 8-bit down counter with a zero flag. It serves both the match
// latency wait and the backoff delay in the snoop issuer.
//   clk, rst  : clock, synchronous active-high clear
//   load      : load load_val (has priority over dec)
//   dec       : decrement, holds at zero
//   zero      : count == 0
module ah_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != 8'd0)
            count <= count - 8'd1;
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/ah_snoop_issuer.sv
// Snoop issuer: accepts one lookup at a time, snoops the FIFO with the key,
// samples the match result MATCH_LAT cycles later, re-snoops after a
// BACKOFF gap on a hit (up to MAX_RETRY times) and returns the outcome.
//   req_*  : lookup request (key, tag), ready only in IDLE
//   sdata/svalid/smatch : snoop channel to the FIFO
//   rsp_*  : response (tag, hit, retry count), held until rsp_ready
//   busy   : any state other than IDLE
module ah_snoop_issuer
    import ah_snoop_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int MATCH_LAT = 1,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [DATA_W-1:0] sdata,
    output logic              svalid,
    input  logic              smatch,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_hit,
    output logic [1:0]        rsp_retries,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              busy
);

    state_t             state, state_nx;
    logic [KEY_W-1:0]   key_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         retry_q, retry_nx;
    logic               hit_q, hit_nx;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [7:0]         cnt_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            key_q   <= '0;
            tag_q   <= '0;
            retry_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            retry_q <= retry_nx;
            hit_q   <= hit_nx;
            if (state == S_IDLE && req_valid) begin
                key_q <= req_key;
                tag_q <= req_tag;
            end
        end
    end

    always_comb begin
        state_nx = state;
        retry_nx = retry_q;
        hit_nx   = hit_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nx = S_ISSUE;
                    retry_nx = '0;
                    hit_nx   = 1'b0;
                end
            end
            S_ISSUE: begin
                // WAIT lasts MATCH_LAT cycles; the last one is the sample.
                cnt_load = 1'b1;
                cnt_val  = 8'(MATCH_LAT - 1);
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (!smatch) begin
                    hit_nx   = 1'b0;
                    state_nx = S_RESP;
                end else if (retry_q < 2'(MAX_RETRY)) begin
                    retry_nx = retry_q + 2'd1;
                    cnt_load = 1'b1;
                    cnt_val  = 8'(BACKOFF - 1);
                    state_nx = S_BACKOFF;
                end else begin
                    hit_nx   = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_BACKOFF: begin
                if (cnt_zero) state_nx = S_ISSUE;
                else          cnt_dec  = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    ah_down_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Outputs are forced to their idle values while rst is high so the
    // reset cycle itself already presents a quiet interface.
    assign req_ready   = (state == S_IDLE) || rst;
    assign busy        = (state != S_IDLE) && !rst;
    assign svalid      = (state == S_ISSUE) && !rst;
    assign sdata       = svalid ? DATA_W'(key_q) : '0;
    assign rsp_valid   = (state == S_RESP) && !rst;
    assign rsp_tag     = rsp_valid ? tag_q   : '0;
    assign rsp_hit     = rsp_valid ? hit_q   : 1'b0;
    assign rsp_retries = rsp_valid ? retry_q : 2'd0;

endmodule

// File: tb/tb_ah_snoop_issuer.sv
module tb_ah_snoop_issuer;

    localparam int DW = 110, KW = 32, TW = 8;
    localparam int ML = 1, MR = 3, BO = 8, MLB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [KW-1:0] req_key;
    logic [TW-1:0] req_tag;
    logic          req_valid_a, req_valid_b, rsp_ready, smatch_a, smatch_b;
    logic          req_ready_a, svalid_a, rsp_hit_a, rsp_valid_a, busy_a;
    logic          req_ready_b, svalid_b, rsp_hit_b, rsp_valid_b, busy_b;
    logic [DW-1:0] sdata_a, sdata_b;
    logic [TW-1:0] rsp_tag_a, rsp_tag_b;
    logic [1:0]    rsp_ret_a, rsp_ret_b;

    ah_snoop_issuer #(.MATCH_LAT(ML), .MAX_RETRY(MR), .BACKOFF(BO)) dut_a (
        .clk(clk), .rst(rst), .req_key(req_key), .req_tag(req_tag),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .sdata(sdata_a), .svalid(svalid_a), .smatch(smatch_a),
        .rsp_tag(rsp_tag_a), .rsp_hit(rsp_hit_a), .rsp_retries(rsp_ret_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .busy(busy_a));

    ah_snoop_issuer #(.MATCH_LAT(MLB), .MAX_RETRY(MR), .BACKOFF(BO)) dut_b (
        .clk(clk), .rst(rst), .req_key(req_key), .req_tag(req_tag),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .sdata(sdata_b), .svalid(svalid_b), .smatch(smatch_b),
        .rsp_tag(rsp_tag_b), .rsp_hit(rsp_hit_b), .rsp_retries(rsp_ret_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .busy(busy_b));

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [TW-1:0] tag;
        logic          hit;
        logic [1:0]    ret;
        int            pulses;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    typedef struct {
        logic [KW-1:0] key;
        logic [TW-1:0] tag;
        logic [3:0]    pat;    // smatch value at sample n is pat[n]
        logic          stray;  // smatch level outside sample cycles
    } vec_t;
    vec_t vecs[6];

    // smatch driver for dut_a (MATCH_LAT=1: sample is the cycle after svalid)
    logic [3:0] pat_a = '0;
    logic       stray_a = 1'b0, samp_next = 1'b0;
    int         pidx = 0, pulses_a = 0, last_sv = 0;
    always @(negedge clk) begin
        if (samp_next) begin
            smatch_a = pat_a[pidx];
            pidx++;
        end else begin
            smatch_a = stray_a;
        end
        samp_next = svalid_a;
        if (svalid_a) begin
            chk("sdata", 128'(sdata_a), 128'(req_key));
            if (pulses_a > 0) chk("svalid_spacing", 128'(cyc - last_sv), 128'(ML + BO + 1));
            last_sv = cyc;
            pulses_a++;
        end
    end

    // response monitor / scoreboard for dut_a
    always @(negedge clk) begin
        if (rsp_valid_a && rsp_ready && !rst) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 128'(sbq.size()), 128'(1));
            end else begin
                e = sbq.pop_front();
                chk("rsp_tag", rsp_tag_a, e.tag);
                chk("rsp_hit", rsp_hit_a, e.hit);
                chk("rsp_retries", rsp_ret_a, e.ret);
                chk("svalid_pulses", 128'(pulses_a), 128'(e.pulses));
            end
        end
    end

    task automatic push_exp(logic [TW-1:0] t, logic [3:0] p);
        exp_t x;
        int r;
        r = 0;
        while (p[r] && r < MR) r++;
        x.tag = t; x.hit = p[r]; x.ret = 2'(r); x.pulses = r + 1;
        sbq.push_back(x);
    endtask

    // Starts at a negedge; returns at the negedge after the handshake.
    task automatic send_a(logic [KW-1:0] k, logic [TW-1:0] t, logic [3:0] p, logic s);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready_a && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("req_ready_timeout", 128'(req_ready_a), 128'(1));
        req_key = k; req_tag = t; pat_a = p; stray_a = s;
        pidx = 0; pulses_a = 0;
        req_valid_a = 1'b1;
        push_exp(t, p);
        @(negedge clk);
        req_valid_a = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin @(negedge clk); n++; end
        chk("rsp_timeout", 128'(sbq.size()), 128'(0));
    endtask

    initial begin
        vecs[0] = '{32'hDEADBEEF, 8'h11, 4'b0000, 1'b0};
        vecs[1] = '{32'h12345678, 8'h22, 4'b1111, 1'b0};
        vecs[2] = '{32'hA5A5A5A5, 8'h33, 4'b0001, 1'b0};
        vecs[3] = '{32'h00000000, 8'h44, 4'b0011, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 8'hFF, 4'b0111, 1'b0};
        vecs[5] = '{32'h0BADF00D, 8'h66, 4'b0000, 1'b1};

        rst = 1'b1; req_key = '0; req_tag = '0; req_valid_a = 1'b0;
        req_valid_b = 1'b0; rsp_ready = 1'b1; smatch_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_req_ready", req_ready_a, 1'b1);
        chk("init_svalid", svalid_a, 1'b0);
        chk("init_sdata", 128'(sdata_a), 128'(0));
        chk("init_rsp", {rsp_valid_a, rsp_tag_a, rsp_hit_a, rsp_ret_a}, '0);
        chk("init_busy", busy_a, 1'b0);
        chk("init_b", {req_ready_b, busy_b, rsp_valid_b, svalid_b}, 4'b1000);

        // Miss with exact cycle timing (T = accept cycle)
        req_key = 32'hDEADBEEF; req_tag = 8'h11; pat_a = 4'b0000; stray_a = 1'b0;
        pidx = 0; pulses_a = 0; req_valid_a = 1'b1;
        push_exp(8'h11, 4'b0000);
        @(negedge clk); req_valid_a = 1'b0;                 // T+1
        chk("t1_svalid", svalid_a, 1'b1);
        chk("t1_sdata", 128'(sdata_a), 128'h00DEADBEEF);
        chk("t1_req_ready", req_ready_a, 1'b0);
        @(negedge clk);                                     // T+2
        chk("t2_svalid", svalid_a, 1'b0);
        chk("t2_sdata_zero", 128'(sdata_a), 128'(0));
        chk("t2_rsp_valid", rsp_valid_a, 1'b0);
        @(negedge clk);                                     // T+3
        chk("t3_rsp_valid", rsp_valid_a, 1'b1);
        @(negedge clk);                                     // T+4
        chk("t4_req_ready", req_ready_a, 1'b1);
        chk("t4_rsp_valid", rsp_valid_a, 1'b0);
        wait_done();

        // Table-driven transactions
        for (int i = 0; i < 6; i++) begin
            send_a(vecs[i].key, vecs[i].tag, vecs[i].pat, vecs[i].stray);
            wait_done();
        end
        stray_a = 1'b0;

        // Response backpressure
        @(posedge clk); #2 rsp_ready = 1'b0;
        send_a(32'hCAFE0001, 8'h77, 4'b0001, 1'b0);
        for (int n = 0; n < 300 && !rsp_valid_a; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid_a, 1'b1);
            chk("bp_rsp_fields", {rsp_tag_a, rsp_hit_a, rsp_ret_a}, {8'h77, 1'b0, 2'd1});
            chk("bp_req_ready", req_ready_a, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_req_ready_after", req_ready_a, 1'b1);
        wait_done();

        // Reset while in BACKOFF
        send_a(32'h5EED5EED, 8'h88, 4'b1111, 1'b0);
        repeat (3) @(negedge clk);
        chk("bo_busy", busy_a, 1'b1);
        chk("bo_svalid", svalid_a, 1'b0);
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("bo_rst_outputs", {req_ready_a, busy_a, svalid_a, rsp_valid_a}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("bo_after_rst", {req_ready_a, busy_a, svalid_a, rsp_valid_a}, 4'b1000);
        send_a(32'h13579BDF, 8'h99, 4'b0001, 1'b0);
        wait_done();

        // Stray smatch on dut_b (MATCH_LAT=3): only svalid+3 decides
        @(negedge clk);
        req_key = 32'h0000BEEF; req_tag = 8'h5B; req_valid_b = 1'b1; smatch_b = 1'b0;
        @(negedge clk); req_valid_b = 1'b0; smatch_b = 1'b1;   // T+1 ISSUE
        chk("b_svalid", svalid_b, 1'b1);
        chk("b_sdata", 128'(sdata_b), 128'h0000BEEF);
        @(negedge clk);                                         // T+2
        @(negedge clk);                                         // T+3
        chk("b_no_early_rsp", rsp_valid_b, 1'b0);
        @(negedge clk); smatch_b = 1'b0;                        // T+4 sample
        chk("b_no_resnoop", svalid_b, 1'b0);
        @(negedge clk); smatch_b = 1'b1;                        // T+5
        chk("b_rsp_valid", rsp_valid_b, 1'b1);
        chk("b_rsp_fields", {rsp_tag_b, rsp_hit_b, rsp_ret_b}, {8'h5B, 1'b0, 2'd0});
        @(negedge clk); smatch_b = 1'b0;
        chk("b_idle", {req_ready_b, busy_b}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ah_snoop_issuer.md
AH_SNOOP_ISSUER -- requirements
Module: ah_snoop_issuer

Interface
REQ-001 SHALL have parameter DATA_W, default 110: width of the snoop data bus driven into the snoopable FIFO.
REQ-002 SHALL have parameter KEY_W, default 32: width of the snoop key compared by the FIFO.
REQ-003 SHALL have parameter TAG_W, default 8: width of the requester tag.
REQ-004 SHALL have parameter MATCH_LAT, default 1, legal range 1..4: cycles from the svalid cycle to the cycle in which smatch is valid.
REQ-005 SHALL have parameter MAX_RETRY, default 3, legal range 0..3: number of re-snoops issued after a hit.
REQ-006 SHALL have parameter BACKOFF, default 8, legal range 1..255: idle cycles between a hit and the next re-snoop.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-009 SHALL have ports req_key (input, KEY_W), req_tag (input, TAG_W), req_valid (input, 1) and req_ready (output, 1): the lookup request channel.
REQ-010 SHALL have ports sdata (output, DATA_W), svalid (output, 1) and smatch (input, 1): the snoop channel to the FIFO.
REQ-011 SHALL have ports rsp_tag (output, TAG_W), rsp_hit (output, 1), rsp_retries (output, 2), rsp_valid (output, 1) and rsp_ready (input, 1): the response channel.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, ISSUE, WAIT, BACKOFF and RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE. On req_valid&req_ready it SHALL capture key and tag, clear the retry counter and move to ISSUE.
REQ-015 SHALL hold svalid=1 for exactly one cycle in ISSUE and then move to WAIT.
REQ-016 SHALL drive sdata[KEY_W-1:0] with the captured key and sdata[DATA_W-1:KEY_W] with 0; sdata SHALL be 0 whenever svalid=0.
REQ-017 SHALL, in WAIT, count MATCH_LAT cycles after the svalid cycle and sample smatch only in the last of those cycles; smatch SHALL be ignored in all other cycles.
REQ-018 SHALL, on a sampled smatch=0, move to RESP with rsp_hit=0.
REQ-019 SHALL, on a sampled smatch=1 with retry count < MAX_RETRY, increment the retry count and move to BACKOFF.
REQ-020 SHALL, in BACKOFF, stay exactly BACKOFF cycles and then move to ISSUE, which re-snoops with the same key.
REQ-021 SHALL, on a sampled smatch=1 with retry count == MAX_RETRY, move to RESP with rsp_hit=1.
REQ-022 SHALL, in RESP, assert rsp_valid with rsp_tag, rsp_hit and rsp_retries (the retry count) held stable until rsp_ready=1. The FSM then moves to IDLE in the next cycle.
REQ-023 SHALL give a miss on the first snoop, with rsp_ready held high, this timing: request accepted in cycle T, svalid in T+1, rsp_valid in T+2+MATCH_LAT, req_ready in T+3+MATCH_LAT.
REQ-024 SHALL NOT have more than one lookup outstanding; req_valid SHALL be ignored outside IDLE.
REQ-025 SHALL have a retry counter that never exceeds MAX_RETRY; with MAX_RETRY=0 any hit goes directly to RESP.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter IDLE, clear the key, tag, retry and delay counters, and abandon any in-flight snoop or pending response.
REQ-027 SHALL have these output values during and after reset: req_ready=1, svalid=0, sdata=0, rsp_valid=0, rsp_tag=0, rsp_hit=0, rsp_retries=0, busy=0.

Structure
REQ-028 SHALL take the FSM state encoding and the default parameter constants (DATA_W, KEY_W, TAG_W) from the shared package ah_snoop_pkg.
REQ-029 SHALL use one sub-module, ah_down_counter (loadable, 8-bit, zero flag), for both the MATCH_LAT wait and the BACKOFF delay.

Verification
REQ-030 Miss: key=0xDEADBEEF, tag=0x11, smatch=0 -> svalid for one cycle with sdata=0x...00DEADBEEF, then rsp_valid with tag=0x11, hit=0, retries=0 at T+3 (MATCH_LAT=1).
REQ-031 Persistent hit: smatch=1 on every sample with MAX_RETRY=3, BACKOFF=8 -> 4 svalid pulses spaced 10 cycles apart, then rsp hit=1, retries=3.
REQ-032 Hit then miss: smatch=1 on the first sample and 0 on the second -> 2 svalid pulses, then rsp hit=0, retries=1.
REQ-033 Response backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0 throughout; req_ready=1 in the cycle after the rsp_ready=1 handshake.
REQ-034 Reset in BACKOFF: rst=1 for 1 cycle -> next cycle IDLE, svalid=0, rsp_valid=0, busy=0, and a new request then completes normally.
REQ-035 Stray smatch: smatch=1 outside the sampling cycle and MATCH_LAT=3 -> the stray pulse is ignored and only the sample 3 cycles after svalid decides the result.
